mc_move_scheduler: RTL and testbench

- Sequences one Monte Carlo statistics engine (`xorshift32` + `logic2048` trial loop) across the four candidate first moves (0..3) for a given board.
- For each move: configures the engine's restricted-move and restrict-probability inputs, seeds it, resets it, runs it until TRIALS trials finish (or timeout), then scores it.
- Reports the move with the highest total move count. Sits between the host/top-level AI loop and the statistics engine.

---
 rtl/mc_move_scheduler_pkg.sv | 35 +++
 rtl/mc_move_scheduler_if.sv | 24 ++
 rtl/mc_move_scheduler_best_tracker.sv | 38 +++
 rtl/mc_move_scheduler.sv | 116 +++++++++++
 tb/tb_mc_move_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_move_scheduler_pkg.sv
// Shared encodings and helpers for the Monte Carlo move scheduler.
package mc_move_scheduler_pkg;

  localparam int BOARD_W = 80;
  localparam int SEED_W  = 8;
  localparam int COUNT_W = 32;
  localparam int MAX_W   = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENG_RST = 3'd1,
    ST_RUN     = 3'd2,
    ST_SCORE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Move numbering is shared with the logic2048 board engine.
  typedef enum logic [1:0] {
    MOVE_UP    = 2'd0,
    MOVE_RIGHT = 2'd1,
    MOVE_DOWN  = 2'd2,
    MOVE_LEFT  = 2'd3
  } move_t;

  localparam logic [1:0] LAST_MOVE = MOVE_LEFT;

  // xorshift32 never leaves the all-zero state, so a zero seed becomes 1.
  function automatic logic [SEED_W-1:0] move_seed(input logic [SEED_W-1:0] base,
                                                  input logic [1:0] idx);
    logic [SEED_W-1:0] s;
    s = base + {6'd0, idx};
    return (s == '0) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/mc_move_scheduler_if.sv
// Control/result bus between the scheduler and one statistics engine.
interface mc_move_scheduler_if;
  import mc_move_scheduler_pkg::*;

  logic               eng_rst;
  logic [1:0]         eng_restrected;
  logic [2:0]         eng_prob;
  logic [BOARD_W-1:0] eng_board;
  logic [SEED_W-1:0]  eng_seed;
  logic [COUNT_W-1:0] eng_total_moves;
  logic [COUNT_W-1:0] eng_trials;
  logic [MAX_W-1:0]   eng_max_moves;

  modport master (
    output eng_rst, eng_restrected, eng_prob, eng_board, eng_seed,
    input  eng_total_moves, eng_trials, eng_max_moves
  );

  modport slave (
    input  eng_rst, eng_restrected, eng_prob, eng_board, eng_seed,
    output eng_total_moves, eng_trials, eng_max_moves
  );

endinterface

// File: rtl/mc_move_scheduler_best_tracker.sv
// Keeps the best candidate move seen so far; ties keep the earlier move.
module mc_best_tracker
  import mc_move_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [1:0]         idx,
  input  logic [COUNT_W-1:0] total,
  input  logic [MAX_W-1:0]   max_moves,
  output logic [1:0]         best_move,
  output logic [COUNT_W-1:0] best_score,
  output logic [MAX_W-1:0]   best_max
);

  logic take;

  // First move always seeds the result; later moves must strictly beat it.
  assign take = load && ((idx == 2'd0) || (total > best_score));

  // Register the winning move, its total and its max move count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_move  <= '0;
      best_score <= '0;
      best_max   <= '0;
    end else if (clear) begin
      best_score <= '0;
      best_max   <= '0;
    end else if (take) begin
      best_move  <= idx;
      best_score <= total;
      best_max   <= max_moves;
    end
  end

endmodule

// File: rtl/mc_move_scheduler.sv
// Runs the statistics engine once per candidate first move and picks the winner.
module mc_move_scheduler
  import mc_move_scheduler_pkg::*;
#(
  parameter logic [31:0] TRIALS  = 32'd64,
  parameter logic [31:0] TIMEOUT = 32'd4000000,
  parameter logic [2:0]  PROB    = 3'd7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [BOARD_W-1:0]     board,
  input  logic [SEED_W-1:0]      seed_base,
  mc_move_scheduler_if.master    eng,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             best_move,
  output logic [COUNT_W-1:0]     best_score,
  output logic [MAX_W-1:0]       best_max,
  output logic [3:0]             timed_out
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [BOARD_W-1:0] board_q;
  logic [SEED_W-1:0]  base_q;
  logic [SEED_W-1:0]  seed_q;
  logic [3:0]         timed_out_q;
  logic               start_accept;
  logic               trials_done;
  logic               run_timeout;

  assign start_accept = (state_q == ST_IDLE) && start && !abort;
  assign trials_done  = (eng.eng_trials >= TRIALS);
  assign run_timeout  = (cnt_q == TIMEOUT - 32'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_accept) state_d = ST_ENG_RST;
      ST_ENG_RST: if (cnt_q == 32'd1) state_d = ST_RUN;
      ST_RUN:     if (trials_done || run_timeout) state_d = ST_SCORE;
      ST_SCORE:   state_d = (idx_q == LAST_MOVE) ? ST_DONE : ST_ENG_RST;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Per-evaluation datapath: latched inputs, move index, seed, cycle counter, timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      board_q     <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      timed_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_accept) begin
          board_q     <= board;
          base_q      <= seed_base;
          idx_q       <= '0;
          cnt_q       <= '0;
          timed_out_q <= '0;
          seed_q      <= move_seed(seed_base, 2'd0);
        end
        ST_ENG_RST: cnt_q <= (cnt_q == 32'd1) ? '0 : cnt_q + 32'd1;
        ST_RUN: begin
          cnt_q <= cnt_q + 32'd1;
          if (run_timeout && !trials_done) timed_out_q[idx_q] <= 1'b1;
        end
        ST_SCORE: if (idx_q != LAST_MOVE) begin
          idx_q  <= idx_q + 2'd1;
          seed_q <= move_seed(base_q, idx_q + 2'd1);
          cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  mc_best_tracker u_best (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_accept),
    .load      (state_q == ST_SCORE),
    .idx       (idx_q),
    .total     (eng.eng_total_moves),
    .max_moves (eng.eng_max_moves),
    .best_move (best_move),
    .best_score(best_score),
    .best_max  (best_max)
  );

  assign eng.eng_rst        = (state_q != ST_RUN);
  assign eng.eng_restrected = idx_q;
  assign eng.eng_prob       = PROB;
  assign eng.eng_board      = board_q;
  assign eng.eng_seed       = seed_q;

  assign busy      = (state_q == ST_ENG_RST) || (state_q == ST_RUN) || (state_q == ST_SCORE);
  assign done      = (state_q == ST_DONE);
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_mc_move_scheduler.sv
// Scoreboard bench for mc_move_scheduler with a behavioural statistics engine.
module tb_mc_move_scheduler;

  localparam logic [31:0] TRIALS  = 32'd10;
  localparam logic [31:0] TIMEOUT = 32'd100;
  localparam logic [2:0]  PROB    = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [79:0] board = '0;
  logic [7:0]  seed_base = '0;
  logic        busy, done;
  logic [1:0]  best_move;
  logic [31:0] best_score;
  logic [14:0] best_max;
  logic [3:0]  timed_out;

  mc_move_scheduler_if eng_bus();

  mc_move_scheduler #(.TRIALS(TRIALS), .TIMEOUT(TIMEOUT), .PROB(PROB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .board     (board),
    .seed_base (seed_base),
    .eng       (eng_bus),
    .busy      (busy),
    .done      (done),
    .best_move (best_move),
    .best_score(best_score),
    .best_max  (best_max),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-move engine behaviour: total increment, start delay, stuck flag, max value.
  int unsigned cfg_inc[4];
  int unsigned cfg_delay[4];
  bit          cfg_stuck[4];
  logic [14:0] cfg_max[4];

  logic [31:0] m_rc, m_trials, m_total;
  logic [14:0] m_max;

  assign eng_bus.eng_trials      = m_trials;
  assign eng_bus.eng_total_moves = m_total;
  assign eng_bus.eng_max_moves   = m_max;

  // Engine model: synchronous active-high reset, one trial per cycle after delay.
  always @(posedge clk) begin
    int unsigned m;
    if (eng_bus.eng_rst) begin
      m_rc <= '0; m_trials <= '0; m_total <= '0; m_max <= '0;
    end else begin
      m = eng_bus.eng_restrected;
      m_rc <= m_rc + 1;
      if (m_rc >= cfg_delay[m]) begin
        if (m_trials < (cfg_stuck[m] ? TRIALS - 1 : TRIALS)) m_trials <= m_trials + 1;
        if (cfg_stuck[m] || (m_trials < TRIALS)) m_total <= m_total + cfg_inc[m];
        m_max <= cfg_max[m];
      end
    end
  end

  typedef struct packed {
    logic [1:0]       move;
    logic [31:0]      score;
    logic [14:0]      mx;
    logic [3:0]       to;
    logic [31:0]      lat;
    logic [31:0]      start_cyc;
    logic [3:0][31:0] run;
  } exp_t;

  exp_t sb[$];

  logic [79:0] cur_board = '0;
  logic [7:0]  cur_base = '0;
  logic [7:0]  seed_log[4];

  function automatic logic [7:0] exp_seed(input logic [7:0] base, input int unsigned i);
    logic [7:0] s;
    s = base + 8'(i);
    if (s == 8'h00) s = 8'h01;
    return s;
  endfunction

  // Monitor: checks engine setup at each RUN entry and pops results on done.
  logic        prev_eng_rst = 1'b1;
  int unsigned run_len = 0;
  int unsigned cur_move = 0;
  int unsigned got_run[4];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_eng_rst = 1'b1;
      run_len = 0;
    end else begin
      if (!eng_bus.eng_rst) begin
        if (prev_eng_rst) begin
          run_len = 1;
          cur_move = eng_bus.eng_restrected;
          seed_log[cur_move] = eng_bus.eng_seed;
          check_output("eng_seed", {24'd0, eng_bus.eng_seed}, {24'd0, exp_seed(cur_base, cur_move)});
          check_output("eng_board", {31'd0, eng_bus.eng_board == cur_board}, 32'd1);
          check_output("eng_prob", {29'd0, eng_bus.eng_prob}, {29'd0, PROB});
        end else begin
          run_len++;
        end
      end else if (!prev_eng_rst && busy) begin
        got_run[cur_move] = run_len;
      end
      prev_eng_rst = eng_bus.eng_rst;
      if (done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("best_move", {30'd0, best_move}, {30'd0, e.move});
          check_output("best_score", best_score, e.score);
          check_output("best_max", {17'd0, best_max}, {17'd0, e.mx});
          check_output("timed_out", {28'd0, timed_out}, {28'd0, e.to});
          check_output("busy_at_done", {31'd0, busy}, 32'd0);
          check_output("latency", cyc - e.start_cyc + 1, e.lat);
          for (int i = 0; i < 4; i++)
            check_output($sformatf("run_len%0d", i), got_run[i], e.run[i]);
        end
      end
    end
  end

  task automatic pulse_start(input logic [79:0] b, input logic [7:0] s, output int unsigned sc);
    @(posedge clk); #1;
    cur_board = b;
    cur_base  = s;
    board     = b;
    seed_base = s;
    start     = 1'b1;
    sc        = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Builds the expected outcome from the engine configuration, then starts.
  task automatic apply_stimulus(input logic [79:0] b, input logic [7:0] s);
    exp_t e;
    logic [31:0] tot;
    int unsigned sc;
    e = '0;
    e.lat = 2;
    for (int i = 0; i < 4; i++) begin
      if (cfg_stuck[i]) begin
        tot = (TIMEOUT - cfg_delay[i]) * cfg_inc[i];
        e.run[i] = TIMEOUT;
        e.to[i] = 1'b1;
      end else begin
        tot = TRIALS * cfg_inc[i];
        e.run[i] = cfg_delay[i] + TRIALS + 1;
      end
      e.lat += 3 + e.run[i];
      if (i == 0 || tot > e.score) begin
        e.move = 2'(i);
        e.score = tot;
        e.mx = cfg_max[i];
      end
    end
    sb.push_back(e);
    pulse_start(b, s, sc);
    sb[sb.size() - 1].start_cyc = sc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_output("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_run(input logic [1:0] mv);
    int n = 0;
    while (!(eng_bus.eng_rst == 1'b0 && eng_bus.eng_restrected == mv) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_output("wait_run", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_done"}, {31'd0, done}, 32'd0);
    check_output({tag, "_eng_rst"}, {31'd0, eng_bus.eng_rst}, 32'd1);
    check_output({tag, "_best_move"}, {30'd0, best_move}, 32'd0);
    check_output({tag, "_best_score"}, best_score, 32'd0);
    check_output({tag, "_best_max"}, {17'd0, best_max}, 32'd0);
    check_output({tag, "_timed_out"}, {28'd0, timed_out}, 32'd0);
    check_output({tag, "_restrected"}, {30'd0, eng_bus.eng_restrected}, 32'd0);
    check_output({tag, "_seed"}, {24'd0, eng_bus.eng_seed}, 32'd0);
    check_output({tag, "_board_zero"}, {31'd0, eng_bus.eng_board == 80'd0}, 32'd1);
    check_output({tag, "_prob"}, {29'd0, eng_bus.eng_prob}, {29'd0, PROB});
  endtask

  task automatic set_cfg(input int unsigned i0, input int unsigned i1,
                         input int unsigned i2, input int unsigned i3);
    cfg_inc[0] = i0; cfg_inc[1] = i1; cfg_inc[2] = i2; cfg_inc[3] = i3;
    for (int i = 0; i < 4; i++) begin
      cfg_delay[i] = 0;
      cfg_stuck[i] = 1'b0;
      cfg_max[i]   = 15'(100 + 11 * i);
    end
  endtask

  initial begin
    int unsigned sc;
    set_cfg(10, 30, 30, 5);
    #23;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Tie between moves 1 and 2, seed wrap with zero substitution, start during RUN.
    apply_stimulus(80'h1234_5678_9ABC_DEF0_1357, 8'hFE);
    wait_run(2'd0);
    @(posedge clk); #1;
    board = 80'hFFFF_0000_FFFF_0000_FFFF;
    seed_base = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("start_ignored_board", {31'd0, eng_bus.eng_board == cur_board}, 32'd1);
    check_output("start_ignored_idx", {30'd0, eng_bus.eng_restrected}, 32'd0);
    wait_done();
    check_output("seed_m0", {24'd0, seed_log[0]}, 32'hFE);
    check_output("seed_m1", {24'd0, seed_log[1]}, 32'hFF);
    check_output("seed_m2", {24'd0, seed_log[2]}, 32'h01);
    check_output("seed_m3", {24'd0, seed_log[3]}, 32'h01);
    repeat (3) @(posedge clk);
    #1 check_output("best_hold", {30'd0, best_move}, 32'd1);

    // Move 2 never finishes its trials and is forced out by the timeout.
    set_cfg(10, 20, 50, 15);
    cfg_stuck[2] = 1'b1;
    apply_stimulus(80'h0A0B_0C0D_0E0F_1011_1213, 8'h20);
    wait_done();

    // Trials complete on the very cycle the timeout would fire.
    set_cfg(7, 2, 3, 4);
    cfg_delay[0] = 89;
    apply_stimulus(80'h2222_3333_4444_5555_6666, 8'h03);
    wait_done();

    // Abort during move 1: no done, idle immediately after.
    set_cfg(10, 30, 30, 5);
    pulse_start(80'h7777_8888_9999_AAAA_BBBB, 8'h40, sc);
    wait_run(2'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_eng_rst", {31'd0, eng_bus.eng_rst}, 32'd1);
    abort = 1'b0;
    repeat (20) @(posedge clk);

    // Reset in the middle of move 2, then a fresh evaluation.
    pulse_start(80'hCCCC_DDDD_EEEE_FFFF_0101, 8'h10, sc);
    wait_run(2'd2);
    #2 rst = 1'b0;
    #1 check_reset_values("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    set_cfg(4, 9, 12, 12);
    apply_stimulus(80'h0F0E_0D0C_0B0A_0908_0706, 8'h00);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
